hanoi_peg_tracker: RTL and testbench

//  Downstream consumer of the Tower of Hanoi move generator's (from_peg, to_peg) stream.

---
 rtl/hanoi_peg_tracker.sv | 136 +++++++++++++
 tb/tb_hanoi_peg_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hanoi_peg_tracker.sv
// Tower of Hanoi board tracker: holds the peg of every disk, checks each incoming
// (from_peg, to_peg) move against the Hanoi rules, commits legal moves and flags
// illegal ones. Terminal states: ERROR after an illegal move, DONE once solved.
module hanoi_peg_tracker #(
  parameter int unsigned NUM_DISKS  = 3,
  parameter int unsigned TARGET_PEG = 3,
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned DISK_W     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 move_valid,
  input  logic [1:0]           from_peg,
  input  logic [1:0]           to_peg,
  output logic                 move_ready,
  output logic                 move_ok,
  output logic                 move_err,
  output logic [DISK_W-1:0]    moved_disk,
  output logic                 illegal,
  output logic                 done,
  output logic [COUNT_W-1:0]   move_count,
  output logic [NUM_DISKS-1:0] peg1_mask,
  output logic [NUM_DISKS-1:0] peg2_mask,
  output logic [NUM_DISKS-1:0] peg3_mask
);

  typedef enum logic [2:0] {StIdle, StCheck, StResp, StError, StDone} state_e;

  state_e      state_q;
  logic [1:0]  board_q [NUM_DISKS];  // peg code (1..3) of each disk
  logic [1:0]  from_q;
  logic [1:0]  to_q;

  logic              from_has;
  logic              to_has;
  logic [DISK_W-1:0] from_top;
  logic [DISK_W-1:0] to_top;
  logic              solved;
  logic              legal;

  // Find the top (lowest index) disk on the captured pegs and whether the board is solved.
  always_comb begin
    from_has = 1'b0;
    from_top = '0;
    to_has   = 1'b0;
    to_top   = '0;
    solved   = 1'b1;
    for (int unsigned i = 0; i < NUM_DISKS; i++) begin
      if (!from_has && board_q[i] == from_q) begin
        from_has = 1'b1;
        from_top = DISK_W'(i);
      end
      if (!to_has && board_q[i] == to_q) begin
        to_has = 1'b1;
        to_top = DISK_W'(i);
      end
      if (board_q[i] != 2'(TARGET_PEG)) solved = 1'b0;
    end
    // Peg code 0 never matches a disk, so an empty or "no peg" source fails from_has.
    legal = (from_q != 2'd0) && (to_q != 2'd0) && (from_q != to_q) && from_has &&
            (!to_has || (to_top > from_top));
  end

  // Occupancy masks are decoded from the board rather than stored.
  always_comb begin
    peg1_mask = '0;
    peg2_mask = '0;
    peg3_mask = '0;
    for (int unsigned i = 0; i < NUM_DISKS; i++) begin
      peg1_mask[i] = (board_q[i] == 2'd1);
      peg2_mask[i] = (board_q[i] == 2'd2);
      peg3_mask[i] = (board_q[i] == 2'd3);
    end
  end

  // Only IDLE accepts; anything presented in other states is simply not taken.
  assign move_ready = (state_q == StIdle);

  // Control FSM with board, counter and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      from_q     <= 2'd0;
      to_q       <= 2'd0;
      move_ok    <= 1'b0;
      move_err   <= 1'b0;
      moved_disk <= '0;
      illegal    <= 1'b0;
      done       <= 1'b0;
      move_count <= '0;
      for (int unsigned i = 0; i < NUM_DISKS; i++) board_q[i] <= 2'd1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (move_valid) begin
            from_q  <= from_peg;
            to_q    <= to_peg;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (legal) begin
            for (int unsigned i = 0; i < NUM_DISKS; i++) begin
              if (DISK_W'(i) == from_top) board_q[i] <= to_q;
            end
            if (move_count != '1) move_count <= move_count + 1'b1;
            move_ok    <= 1'b1;
            moved_disk <= from_top;
          end else begin
            move_err <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          move_ok    <= 1'b0;
          move_err   <= 1'b0;
          moved_disk <= '0;
          // move_err still carries this move's verdict during RESP.
          if (move_err) begin
            illegal <= 1'b1;
            state_q <= StError;
          end else if (solved) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StIdle;
          end
        end
        StError: state_q <= StError;
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hanoi_peg_tracker.sv
// Directed bench for hanoi_peg_tracker (3 disks, target peg 3).
module tb_hanoi_peg_tracker;

  logic       clock;
  logic       reset;
  logic       move_valid;
  logic [1:0] from_peg;
  logic [1:0] to_peg;
  logic       move_ready;
  logic       move_ok;
  logic       move_err;
  logic [1:0] moved_disk;
  logic       illegal;
  logic       done;
  logic [7:0] move_count;
  logic [2:0] peg1_mask;
  logic [2:0] peg2_mask;
  logic [2:0] peg3_mask;

  int vectors;
  int miscompares;

  hanoi_peg_tracker #(
    .NUM_DISKS (3),
    .TARGET_PEG(3),
    .COUNT_W   (8),
    .DISK_W    (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .move_valid(move_valid),
    .from_peg  (from_peg),
    .to_peg    (to_peg),
    .move_ready(move_ready),
    .move_ok   (move_ok),
    .move_err  (move_err),
    .moved_disk(moved_disk),
    .illegal   (illegal),
    .done      (done),
    .move_count(move_count),
    .peg1_mask (peg1_mask),
    .peg2_mask (peg2_mask),
    .peg3_mask (peg3_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset      = 1'b1;
    move_valid = 1'b0;
    from_peg   = 2'd0;
    to_peg     = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Present one move when ready, then sample the CHECK cycle and the RESP cycle.
  task automatic do_move(input logic [1:0] f, input logic [1:0] t, output logic pre_pulse,
                         output logic ok, output logic err, output logic [1:0] disk);
    int waited = 0;
    pre_pulse = 1'b0;
    ok = 1'b0;
    err = 1'b0;
    disk = 2'd0;
    @(negedge clock);
    while (!move_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!move_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL do_move_ready_timeout got move_ready=%b want 1", move_ready);
      return;
    end
    move_valid = 1'b1;
    from_peg   = f;
    to_peg     = t;
    @(posedge clock);
    #1 move_valid = 1'b0;
    @(negedge clock);
    pre_pulse = move_ok | move_err;
    @(negedge clock);
    ok   = move_ok;
    err  = move_err;
    disk = moved_disk;
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (peg1_mask !== 3'b111) begin miscompares++; $display("FAIL reset_peg1 got %b want 111", peg1_mask); end
    vectors++; if (peg2_mask !== 3'b000) begin miscompares++; $display("FAIL reset_peg2 got %b want 000", peg2_mask); end
    vectors++; if (peg3_mask !== 3'b000) begin miscompares++; $display("FAIL reset_peg3 got %b want 000", peg3_mask); end
    vectors++; if (move_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", move_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (move_count !== 8'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", move_count); end
    vectors++; if ({move_ok, move_err, illegal} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {move_ok, move_err, illegal}); end
  endtask

  task automatic test_full_solution();
    logic [1:0] froms [7] = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1};
    logic [1:0] tos   [7] = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
    logic [1:0] disks [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    logic pre, ok, err;
    logic [1:0] disk;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      do_move(froms[i], tos[i], pre, ok, err, disk);
      vectors++; if ({pre, ok, err} !== 3'b010) begin miscompares++; $display("FAIL solve_pulse[%0d] got pre/ok/err=%b want 010", i, {pre, ok, err}); end
      vectors++; if (disk !== disks[i]) begin miscompares++; $display("FAIL solve_disk[%0d] got %0d want %0d", i, disk, disks[i]); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL solve_done got %b want 1", done); end
    vectors++; if (move_count !== 8'd7) begin miscompares++; $display("FAIL solve_count got %0d want 7", move_count); end
    vectors++; if (peg3_mask !== 3'b111) begin miscompares++; $display("FAIL solve_peg3 got %b want 111", peg3_mask); end
    vectors++; if (move_ready !== 1'b0) begin miscompares++; $display("FAIL solve_ready got %b want 0", move_ready); end
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL solve_illegal got %b want 0", illegal); end
  endtask

  task automatic test_larger_on_smaller();
    logic pre, ok, err;
    logic [1:0] disk;
    apply_reset();
    do_move(2'd1, 2'd3, pre, ok, err, disk);
    vectors++; if ({ok, err, disk} !== 4'b1000) begin miscompares++; $display("FAIL big_first got ok/err/disk=%b want 1000", {ok, err, disk}); end
    do_move(2'd1, 2'd3, pre, ok, err, disk);
    vectors++; if ({pre, ok, err, disk} !== 5'b00100) begin miscompares++; $display("FAIL big_second got pre/ok/err/disk=%b want 00100", {pre, ok, err, disk}); end
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL big_illegal got %b want 1", illegal); end
    vectors++; if (peg3_mask !== 3'b001) begin miscompares++; $display("FAIL big_peg3 got %b want 001", peg3_mask); end
    vectors++; if (peg1_mask !== 3'b110) begin miscompares++; $display("FAIL big_peg1 got %b want 110", peg1_mask); end
    vectors++; if (move_count !== 8'd1) begin miscompares++; $display("FAIL big_count got %0d want 1", move_count); end
    // A valid-looking move in ERROR must be ignored.
    move_valid = 1'b1;
    from_peg   = 2'd1;
    to_peg     = 2'd2;
    repeat (5) @(negedge clock);
    move_valid = 1'b0;
    vectors++; if (move_ready !== 1'b0) begin miscompares++; $display("FAIL big_ready_stuck got %b want 0", move_ready); end
    vectors++; if ({peg1_mask, peg2_mask, peg3_mask} !== 9'b110_000_001) begin miscompares++; $display("FAIL big_board_frozen got %b want 110000001", {peg1_mask, peg2_mask, peg3_mask}); end
    vectors++; if (move_count !== 8'd1) begin miscompares++; $display("FAIL big_count_frozen got %0d want 1", move_count); end
  endtask

  task automatic test_malformed();
    logic [1:0] froms [4] = '{2'd2, 2'd1, 2'd0, 2'd1};
    logic [1:0] tos   [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic pre, ok, err;
    logic [1:0] disk;
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      do_move(froms[i], tos[i], pre, ok, err, disk);
      vectors++; if ({pre, ok, err} !== 3'b001) begin miscompares++; $display("FAIL bad[%0d]_pulse got pre/ok/err=%b want 001", i, {pre, ok, err}); end
      vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL bad[%0d]_illegal got %b want 1", i, illegal); end
      vectors++; if ({peg1_mask, peg2_mask, peg3_mask} !== 9'b111_000_000) begin miscompares++; $display("FAIL bad[%0d]_board got %b want 111000000", i, {peg1_mask, peg2_mask, peg3_mask}); end
      vectors++; if (move_count !== 8'd0) begin miscompares++; $display("FAIL bad[%0d]_count got %0d want 0", i, move_count); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] froms [3] = '{2'd1, 2'd1, 2'd3};
    logic [1:0] tos   [3] = '{2'd3, 2'd2, 2'd2};
    int acc_cyc [3];
    int idx = 0;
    int oks = 0;
    int errs = 0;
    apply_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 3) begin
        move_valid = 1'b1;
        from_peg   = froms[idx];
        to_peg     = tos[idx];
      end else begin
        move_valid = 1'b0;
      end
      if (move_valid && move_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      if (move_ok) oks++;
      if (move_err) errs++;
      @(negedge clock);
    end
    move_valid = 1'b0;
    vectors++; if (idx !== 3) begin miscompares++; $display("FAIL b2b_accepts got %0d want 3", idx); end
    if (idx == 3) begin
      vectors++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin miscompares++; $display("FAIL b2b_gap01 got %0d want 3", acc_cyc[1] - acc_cyc[0]); end
      vectors++; if (acc_cyc[2] - acc_cyc[1] !== 3) begin miscompares++; $display("FAIL b2b_gap12 got %0d want 3", acc_cyc[2] - acc_cyc[1]); end
    end
    vectors++; if (oks !== 3 || errs !== 0) begin miscompares++; $display("FAIL b2b_pulses got ok=%0d err=%0d want ok=3 err=0", oks, errs); end
    vectors++; if (move_count !== 8'd3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", move_count); end
    vectors++; if ({peg1_mask, peg2_mask, peg3_mask} !== 9'b100_011_000) begin miscompares++; $display("FAIL b2b_board got %b want 100011000", {peg1_mask, peg2_mask, peg3_mask}); end
  endtask

  task automatic test_reset_mid_move();
    int pulses = 0;
    apply_reset();
    move_valid = 1'b1;
    from_peg   = 2'd1;
    to_peg     = 2'd2;
    @(posedge clock);
    #1 move_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++; if (peg1_mask !== 3'b111) begin miscompares++; $display("FAIL midrst_peg1 got %b want 111", peg1_mask); end
    vectors++; if ({move_ok, move_err} !== 2'b00) begin miscompares++; $display("FAIL midrst_pulse got %b want 00", {move_ok, move_err}); end
    vectors++; if (move_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", move_ready); end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      if (move_ok || move_err) pulses++;
      @(negedge clock);
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst_late_pulse got %0d want 0", pulses); end
    vectors++; if (move_count !== 8'd0 || peg2_mask !== 3'b000) begin miscompares++; $display("FAIL midrst_state got count=%0d peg2=%b want 0/000", move_count, peg2_mask); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    move_valid  = 1'b0;
    from_peg    = 2'd0;
    to_peg      = 2'd0;
    test_reset();
    test_full_solution();
    test_larger_on_smaller();
    test_malformed();
    test_back_to_back();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
